// File: rtl/tdc_merge_fifo.sv
// tdc_merge_fifo: merges N_CH timestamp channels into one first-word-fall-through
// FIFO. Each channel owns a one-entry holding register. A round-robin arbiter
// moves at most one held word per cycle into shared storage, and tags each word
// with its source channel ID. Holding-register overruns are counted as drops.

// Per-channel holding register. A hit is captured when the slot is empty or is
// being drained this cycle. A hit that arrives while the word is still waiting
// for a grant is dropped.
module tdc_merge_hold #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hit,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  grant,
  output logic                  vld,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  drop
);

  assign drop = hit & vld & ~grant;

  // capture, reload on grant, or release on grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (hit && (!vld || grant)) begin
      vld  <= 1'b1;
      data <= din;
    end else if (grant) begin
      vld  <= 1'b0;
    end
  end

endmodule

module tdc_merge_fifo #(
  parameter int DATA_WIDTH          = 32,
  parameter int N_CH                = 4,
  parameter int DEPTH_LOG2          = 9,
  parameter int ALMOST_FULL_OFFSET  = 128,
  parameter int ALMOST_EMPTY_OFFSET = 128,
  localparam int CH_BITS = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int OUT_W   = CH_BITS + DATA_WIDTH,
  localparam int PTR_W   = DEPTH_LOG2 + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CH-1:0]              WriteEN,
  input  logic [N_CH*DATA_WIDTH-1:0]   data_input,
  input  logic                         ReadEN,
  output logic [OUT_W-1:0]             data_output,
  output logic [PTR_W-1:0]             count,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_empty,
  output logic                         almost_full,
  output logic                         readERR,
  output logic                         writeERR,
  output logic [15:0]                  drop_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [PTR_W-1:0] P_ONE = 1;

  logic [N_CH-1:0]                 hold_vld;
  logic [N_CH-1:0][DATA_WIDTH-1:0] hold_data;
  logic [N_CH-1:0]                 grant_oh;
  logic [N_CH-1:0]                 drop;

  logic               gnt_vld;
  logic [CH_BITS-1:0] gnt_ch;
  logic [CH_BITS-1:0] cand;
  logic [CH_BITS-1:0] last_grant;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             rd_en;
  logic [16:0]      ndrop, drop_sum;

  logic [OUT_W-1:0] mem [DEPTH];

  // per-channel holding registers
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign grant_oh[c] = gnt_vld && (gnt_ch == CH_BITS'(c));
    tdc_merge_hold #(.DATA_WIDTH(DATA_WIDTH)) u_hold (
      .clk   (clk),
      .rst   (rst),
      .hit   (WriteEN[c]),
      .din   (data_input[c*DATA_WIDTH +: DATA_WIDTH]),
      .grant (grant_oh[c]),
      .vld   (hold_vld[c]),
      .data  (hold_data[c]),
      .drop  (drop[c])
    );
  end

  // round-robin pick: first held channel after last_grant; nothing while full
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    cand    = '0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = CH_BITS'((int'(last_grant) + i) % N_CH);
      if (!gnt_vld && !full && hold_vld[cand]) begin
        gnt_vld = 1'b1;
        gnt_ch  = cand;
      end
    end
  end

  assign rd_en = ReadEN & ~empty;

  // storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (gnt_vld) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {gnt_ch, hold_data[gnt_ch]};
  end

  // pointers, occupancy and arbiter history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= CH_BITS'(N_CH - 1);
    end else begin
      if (gnt_vld) begin
        wr_ptr     <= wr_ptr + P_ONE;
        last_grant <= gnt_ch;
      end
      if (rd_en) rd_ptr <= rd_ptr + P_ONE;
      case ({gnt_vld, rd_en})
        2'b10:   count <= count + P_ONE;
        2'b01:   count <= count - P_ONE;
        default: count <= count;
      endcase
    end
  end

  // number of channels dropping this cycle, added onto the running total
  always_comb begin
    ndrop = '0;
    for (int c = 0; c < N_CH; c++) ndrop = ndrop + 17'(drop[c]);
    drop_sum = 17'(drop_count) + ndrop;
  end

  // error pulses and saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readERR    <= 1'b0;
      writeERR   <= 1'b0;
      drop_count <= '0;
    end else begin
      readERR    <= ReadEN & empty;
      writeERR   <= |drop;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign full         = (count == PTR_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (int'(count) >= DEPTH - ALMOST_FULL_OFFSET);
  assign almost_empty = (int'(count) <= ALMOST_EMPTY_OFFSET);
  assign data_output  = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: tb/tb_tdc_merge_fifo.sv
// Bench for tdc_merge_fifo: directed vector table, hand sequences for full/wrap,
// push+pop and async reset, randomized traffic and drop-counter saturation, all
// compared against a queue-based reference model.
module tb_tdc_merge_fifo;

  localparam int DW    = 32;
  localparam int NC    = 4;
  localparam int DL    = 4;
  localparam int AFO   = 4;
  localparam int AEO   = 2;
  localparam int DEPTH = 16;
  localparam int CHB   = 2;
  localparam int OW    = CHB + DW;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NC-1:0]          WriteEN;
  logic [NC-1:0][DW-1:0]  din_v;
  logic [NC*DW-1:0]       data_input;
  logic                   ReadEN;
  logic [OW-1:0]          data_output;
  logic [DL:0]            count;
  logic                   empty, full, almost_empty, almost_full;
  logic                   readERR, writeERR;
  logic [15:0]            drop_count;

  assign data_input = din_v;

  tdc_merge_fifo #(
    .DATA_WIDTH(DW), .N_CH(NC), .DEPTH_LOG2(DL),
    .ALMOST_FULL_OFFSET(AFO), .ALMOST_EMPTY_OFFSET(AEO)
  ) dut (
    .clk(clk), .rst(rst), .WriteEN(WriteEN), .data_input(data_input),
    .ReadEN(ReadEN), .data_output(data_output), .count(count),
    .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .readERR(readERR), .writeERR(writeERR),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [OW-1:0] m_q[$];
  logic [DW-1:0] m_hd[NC];
  bit            m_hv[NC];
  int            m_last;
  int            m_drop;
  bit            m_werr, m_rerr;

  task automatic model_reset();
    m_q.delete();
    for (int c = 0; c < NC; c++) begin m_hv[c] = 0; m_hd[c] = '0; end
    m_last = NC - 1;
    m_drop = 0;
    m_werr = 0;
    m_rerr = 0;
  endtask

  task automatic model_step(input logic [NC-1:0] we, input logic [NC-1:0][DW-1:0] d, input logic re);
    int  g, nd;
    bit  was_full, was_empty;
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    g = -1;
    if (!was_full)
      for (int i = 1; i <= NC; i++) begin
        int c;
        c = (m_last + i) % NC;
        if (g < 0 && m_hv[c]) g = c;
      end
    m_rerr = re && was_empty;
    if (re && !was_empty) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back({CHB'(g), m_hd[g]});
      m_last = g;
    end
    nd = 0;
    for (int c = 0; c < NC; c++) begin
      if (we[c]) begin
        if (!m_hv[c] || c == g) begin m_hv[c] = 1; m_hd[c] = d[c]; end
        else nd++;
      end else if (c == g) m_hv[c] = 0;
    end
    m_werr = (nd > 0);
    m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
  endtask

  task automatic check_model();
    int n;
    n = m_q.size();
    chk("m_data",  data_output, (n > 0) ? m_q[0] : '0);
    chk("m_count", count, n);
    chk("m_empty", empty, n == 0);
    chk("m_full",  full, n == DEPTH);
    chk("m_aempty", almost_empty, n <= AEO);
    chk("m_afull", almost_full, n >= DEPTH - AFO);
    chk("m_rerr",  readERR, m_rerr);
    chk("m_werr",  writeERR, m_werr);
    chk("m_drop",  drop_count, m_drop);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_aempty"}, almost_empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_afull"}, almost_full, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_data"}, data_output, 0);
    chk({tag, "_rerr"}, readERR, 0);
    chk({tag, "_werr"}, writeERR, 0);
    chk({tag, "_drop"}, drop_count, 0);
  endtask

  // one clock: drive inputs, model the edge, sample 1ns later
  task automatic cycle(input logic [NC-1:0] we, input logic [NC-1:0][DW-1:0] d,
                       input logic re, input bit do_chk = 1);
    WriteEN = we;
    din_v   = d;
    ReadEN  = re;
    @(posedge clk);
    model_step(we, d, re);
    #1;
    if (do_chk) check_model();
  endtask

  // asynchronous reset asserted between edges, checked before any edge
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    WriteEN = '0;
    ReadEN  = 1'b0;
    #1;
    chk_reset_vals(tag);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit                    rst;
    logic [NC-1:0]         we;
    logic [NC-1:0][DW-1:0] d;
    bit                    re;
    int                    e_cnt;
    bit                    e_emp;
    logic [OW-1:0]         e_data;
    bit                    e_werr;
    bit                    e_rerr;
    int                    e_drop;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit r, logic [3:0] we, logic [31:0] d0, logic [31:0] d1,
                              logic [31:0] d2, logic [31:0] d3, bit re, int cnt, bit emp,
                              logic [OW-1:0] dat, bit werr, bit rerr, int drp);
    vec_t v;
    v.rst = r; v.we = we; v.re = re;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.e_cnt = cnt; v.e_emp = emp; v.e_data = dat;
    v.e_werr = werr; v.e_rerr = rerr; v.e_drop = drp;
    return v;
  endfunction

  logic [NC-1:0][DW-1:0] dz;
  logic [NC-1:0][DW-1:0] dr;

  initial begin
    rst = 1'b1; WriteEN = '0; ReadEN = 1'b0; din_v = '0; dz = '0;
    model_reset();
    #1;
    chk_reset_vals("por");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // single hit, round robin, drop path, read-while-empty
    vq.push_back(mk(0, 4'b0100, 0, 0, 32'hDEADBEEF, 0, 0, 0, 1, '0, 0, 0, 0));
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 1, 0, {2'd2, 32'hDEADBEEF}, 0, 0, 0));
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 0, 1, '0, 0, 0, 0));
    vq.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0, 1, '0, 0, 0, 0));
    vq.push_back(mk(0, 4'b1111, 0, 1, 2, 3, 0, 0, 1, '0, 0, 0, 0));
    vq.push_back(mk(0, 4'b0001, 32'h10, 0, 0, 0, 0, 1, 0, {2'd0, 32'd0}, 0, 0, 0));
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 2, 0, {2'd0, 32'd0}, 0, 0, 0));
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 3, 0, {2'd0, 32'd0}, 0, 0, 0));
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 4, 0, {2'd0, 32'd0}, 0, 0, 0));
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 5, 0, {2'd0, 32'd0}, 0, 0, 0));
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 4, 0, {2'd1, 32'd1}, 0, 0, 0));
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 3, 0, {2'd2, 32'd2}, 0, 0, 0));
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 2, 0, {2'd3, 32'd3}, 0, 0, 0));
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 1, 0, {2'd0, 32'h10}, 0, 0, 0));
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 0, 1, '0, 0, 0, 0));
    vq.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0, 1, '0, 0, 0, 0));
    vq.push_back(mk(0, 4'b0111, 32'hA0A00000, 32'hB1, 32'hC2, 0, 0, 0, 1, '0, 0, 0, 0));
    vq.push_back(mk(0, 4'b0010, 0, 32'hB2, 0, 0, 0, 1, 0, {2'd0, 32'hA0A00000}, 1, 0, 1));
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 2, 0, {2'd0, 32'hA0A00000}, 0, 0, 1));
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 3, 0, {2'd0, 32'hA0A00000}, 0, 0, 1));
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 2, 0, {2'd1, 32'hB1}, 0, 0, 1));
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 1, 0, {2'd2, 32'hC2}, 0, 0, 1));
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 0, 1, '0, 0, 0, 1));
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 0, 1, '0, 0, 1, 1));
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 0, 1, '0, 0, 0, 1));

    foreach (vq[i]) begin
      if (vq[i].rst) do_reset($sformatf("v%0d_rst", i));
      else begin
        cycle(vq[i].we, vq[i].d, vq[i].re);
        chk($sformatf("v%0d_cnt", i),  count,       vq[i].e_cnt);
        chk($sformatf("v%0d_emp", i),  empty,       vq[i].e_emp);
        chk($sformatf("v%0d_data", i), data_output, vq[i].e_data);
        chk($sformatf("v%0d_werr", i), writeERR,    vq[i].e_werr);
        chk($sformatf("v%0d_rerr", i), readERR,     vq[i].e_rerr);
        chk($sformatf("v%0d_drop", i), drop_count,  vq[i].e_drop);
      end
    end

    // full and wrap
    do_reset("fw_rst");
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < NC; c++) dr[c] = 32'd100 + i;
      cycle(4'b0001 << (i % 4), dr, 0);
      if (m_q.size() == 11) chk("af_below", almost_full, 0);
      if (m_q.size() == 12) chk("af_at_12", almost_full, 1);
    end
    for (int c = 0; c < NC; c++) dr[c] = 32'd200 + c;
    cycle(4'b1111, dr, 0);
    chk("fw_full", full, 1);
    chk("fw_cnt16", count, 16);
    cycle(4'b1111, dr, 0);
    chk("fw_stall_drop", writeERR, 1);
    chk("fw_stall_cnt", count, 16);
    cycle('0, dz, 1);
    chk("fw_pop_cnt", count, 15);
    cycle('0, dz, 0);
    chk("fw_one_in", count, 16);
    cycle('0, dz, 0);
    chk("fw_only_one", count, 16);
    for (int j = 0; j < 40; j++) begin
      for (int c = 0; c < NC; c++) dr[c] = $urandom;
      cycle(4'b0001 << (j % 4), dr, 1);
    end

    // simultaneous push and pop at count 5
    do_reset("pp_rst");
    for (int i = 0; i < 5; i++) begin
      dr = dz; dr[0] = 32'd300 + i;
      cycle(4'b0001, dr, 0);
    end
    cycle('0, dz, 0);
    chk("pp_cnt5", count, 5);
    dr = dz; dr[1] = 32'h555;
    cycle(4'b0010, dr, 0);
    cycle('0, dz, 1);
    chk("pp_cnt_same", count, 5);
    chk("pp_head_adv", data_output, {2'd0, 32'd301});

    // async reset mid-operation: count 7, two channels holding
    do_reset("ar_rst0");
    for (int i = 0; i < 6; i++) begin
      dr = dz; dr[3] = 32'd400 + i;
      cycle(4'b1000, dr, 0);
    end
    cycle('0, dz, 0);
    dr = dz; dr[0] = 32'd500; dr[1] = 32'd501; dr[2] = 32'd502;
    cycle(4'b0111, dr, 0);
    dr = dz; dr[1] = 32'd601; dr[2] = 32'd602;
    cycle(4'b0110, dr, 0);
    chk("ar_cnt7", count, 7);
    chk("ar_drop2", drop_count, 2);
    do_reset("ar_mid");
    dr = dz; dr[1] = 32'h777;
    cycle(4'b0010, dr, 0);
    cycle('0, dz, 0);
    chk("ar_first", data_output, {2'd1, 32'h777});
    chk("ar_first_cnt", count, 1);

    // randomized traffic with shifting read pressure
    do_reset("rnd_rst");
    for (int j = 0; j < 600; j++) begin
      int rp;
      rp = ((j / 100) % 2 == 0) ? 25 : 85;
      for (int c = 0; c < NC; c++) dr[c] = $urandom;
      cycle(NC'($urandom & $urandom), dr, ($urandom_range(0, 99) < rp));
    end

    // drop counter saturation: stay full with every channel hitting
    do_reset("sat_rst");
    for (int c = 0; c < NC; c++) dr[c] = 32'hC0DE0000 + c;
    for (int j = 0; j < 16500; j++) cycle(4'b1111, dr, 0, 0);
    check_model();
    chk("sat_drop", drop_count, 16'hFFFF);
    cycle(4'b1111, dr, 0);
    chk("sat_hold", drop_count, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
